// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared constants, FSM state type and packet helpers for the
// mtm_Alu serial output path.
//   PKT_DATA / PKT_CTL  : packet type bit values
//   START_BIT / STOP_BIT: packet framing bits
//   ERR_*               : error-flag encodings carried in error frames
//   CRC3_POLY           : CRC3 polynomial x^3+x+1 (x^3 term implicit)
package mtm_alu_pkg;

  localparam logic PKT_DATA  = 1'b0;
  localparam logic PKT_CTL   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  localparam logic [2:0] CRC3_POLY = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } ser_state_t;

  // 11-bit packet, transmitted from bit 10 down to bit 0.
  function automatic logic [10:0] make_pkt(input logic pkt_type, input logic [7:0] payload);
    return {START_BIT, pkt_type, payload, STOP_BIT};
  endfunction

  // Error payload carries an even-parity bit so the whole byte has even weight.
  function automatic logic [7:0] err_payload(input logic [5:0] err_flags);
    return {1'b1, err_flags, ^{1'b1, err_flags}};
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// mtm_alu_serializer_if: transaction handshake between the ALU core (master)
// and the serializer (slave).
//   start, is_err       : request and frame kind
//   data_c, flags       : result payload
//   err_flags           : error-frame payload
//   ready               : serializer idle and able to accept start
interface mtm_alu_serializer_if;
  logic        start;
  logic        is_err;
  logic [31:0] data_c;
  logic [3:0]  flags;
  logic [5:0]  err_flags;
  logic        ready;

  modport master (output start, is_err, data_c, flags, err_flags, input ready);
  modport slave  (input start, is_err, data_c, flags, err_flags, output ready);
endinterface

// File: rtl/mtm_alu_crc3.sv
// mtm_alu_crc3: combinational CRC3, MSB first, initial value zero.
//   din : 37-bit message {data_c, 1'b0, flags}
//   crc : 3-bit remainder
module mtm_alu_crc3
  import mtm_alu_pkg::*;
#(
  parameter logic [2:0] POLY = CRC3_POLY
) (
  input  logic [36:0] din,
  output logic [2:0]  crc
);

  always_comb begin
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      if (crc[2] ^ din[i]) crc = {crc[1:0], 1'b0} ^ POLY;
      else                 crc = {crc[1:0], 1'b0};
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: transmits one result frame (4 DATA + 1 CTL packet) or
// one error frame (1 CTL packet) per accepted start onto sout.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of the start/ready handshake and payload
//   sout     : serial line, idles high
//
// state   | meaning
// IDLE    | sout high, ready high, waiting for start
// SEND    | shifting packets out, one bit per CLKS_PER_BIT cycles
// DONE    | frame finished, ready high; a start here begins the next frame
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1,
  parameter logic [2:0] CRC_POLY     = CRC3_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  mtm_alu_serializer_if.slave  bus,
  output logic                 sout
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  ser_state_t        state, state_nxt;
  logic [10:0]       pkt_reg;
  logic [3:0]        bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        pkt_cnt;
  logic [2:0]        last_pkt;
  logic [31:0]       data_l;
  logic [3:0]        flags_l;
  logic [2:0]        crc;

  logic              accept;
  logic              bit_end;
  logic              pkt_end;
  logic [10:0]       first_pkt;
  logic [10:0]       next_pkt;

  mtm_alu_crc3 #(.POLY(CRC_POLY)) u_crc (
    .din ({data_l, 1'b0, flags_l}),
    .crc (crc)
  );

  assign accept  = (state != ST_SEND) && bus.start;
  assign bit_end = (div_cnt == DIV_LAST);
  assign pkt_end = bit_end && (bit_cnt == 4'd10);

  // The first packet comes straight from the inputs so its start bit can go
  // out on the accepting edge; later packets use the latched copies.
  always_comb begin
    first_pkt = make_pkt(PKT_DATA, bus.data_c[31:24]);
    if (bus.is_err) first_pkt = make_pkt(PKT_CTL, err_payload(bus.err_flags));
  end

  always_comb begin
    next_pkt = make_pkt(PKT_CTL, {1'b0, flags_l, crc});
    case (pkt_cnt + 3'd1)
      3'd1:    next_pkt = make_pkt(PKT_DATA, data_l[23:16]);
      3'd2:    next_pkt = make_pkt(PKT_DATA, data_l[15:8]);
      3'd3:    next_pkt = make_pkt(PKT_DATA, data_l[7:0]);
      default: next_pkt = make_pkt(PKT_CTL, {1'b0, flags_l, crc});
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.ready = 1'b1;
    sout      = 1'b1;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = bus.start ? ST_SEND : ST_IDLE;
      end
      ST_SEND: begin
        bus.ready = 1'b0;
        sout      = pkt_reg[10];
        if (pkt_end && (pkt_cnt == last_pkt)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_reg  <= '1;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      pkt_cnt  <= '0;
      last_pkt <= '0;
      data_l   <= '0;
      flags_l  <= '0;
    end else if (accept) begin
      pkt_reg  <= first_pkt;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      pkt_cnt  <= '0;
      last_pkt <= bus.is_err ? 3'd0 : 3'd4;
      data_l   <= bus.data_c;
      flags_l  <= bus.flags;
    end else if (state == ST_SEND) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (pkt_cnt != last_pkt) begin
            pkt_reg <= next_pkt;
            pkt_cnt <= pkt_cnt + 3'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          pkt_reg <= {pkt_reg[9:0], 1'b1};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;
  import mtm_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sout_a, sout_b;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [10:0] exp_pkts [5];
  logic [10:0] got_pkts [5];
  int          exp_n;

  always #5 clk = ~clk;

  mtm_alu_serializer_if bus_a ();
  mtm_alu_serializer_if bus_b ();

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a.slave),
    .sout (sout_a)
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b.slave),
    .sout (sout_b)
  );

  // Remainder of v*x^3 divided by x^3+x+1, by polynomial long division.
  function automatic logic [2:0] ref_crc(input logic [36:0] v);
    logic [39:0] r;
    r = {v, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [10:0] ref_pkt(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  task automatic build_exp(input logic err, input logic [31:0] c,
                           input logic [3:0] f, input logic [5:0] e);
    logic par;
    if (err) begin
      par = ^{1'b1, e};
      exp_n = 1;
      exp_pkts[0] = ref_pkt(1'b1, {1'b1, e, par});
    end else begin
      exp_n = 5;
      exp_pkts[0] = ref_pkt(1'b0, c[31:24]);
      exp_pkts[1] = ref_pkt(1'b0, c[23:16]);
      exp_pkts[2] = ref_pkt(1'b0, c[15:8]);
      exp_pkts[3] = ref_pkt(1'b0, c[7:0]);
      exp_pkts[4] = ref_pkt(1'b1, {1'b0, f, ref_crc({c, 1'b0, f})});
    end
  endtask

  // Sends one frame on dut_a, deserialises sout and compares every packet.
  // chain=1 asserts start in the current (ready) cycle with no idle gap.
  // mid=1 pulses start with corrupted inputs during the frame.
  task automatic run_frame_a(input string name, input logic err, input logic [31:0] c,
                             input logic [3:0] f, input logic [5:0] e,
                             input bit chain, input bit mid);
    logic [10:0] got;
    int rdy_bad;
    build_exp(err, c, f, e);
    if (!chain) @(negedge clk);
    bus_a.start = 1'b1; bus_a.is_err = err; bus_a.data_c = c;
    bus_a.flags = f; bus_a.err_flags = e;
    @(negedge clk);
    bus_a.start = 1'b0;
    rdy_bad = 0;
    for (int p = 0; p < exp_n; p++) begin
      for (int b = 0; b < 11; b++) begin
        got[10-b] = sout_a;
        if (bus_a.ready !== 1'b0) rdy_bad++;
        if (mid && (p*11 + b == 10)) begin
          bus_a.start = 1'b1; bus_a.is_err = ~err; bus_a.data_c = ~c;
          bus_a.flags = ~f; bus_a.err_flags = ~e;
        end
        if (mid && (p*11 + b == 30)) bus_a.start = 1'b0;
        @(negedge clk);
      end
      got_pkts[p] = got;
      n_cmp++;
      if (got !== exp_pkts[p]) begin
        n_err++;
        $display("FAIL %s pkt%0d got %b want %b", name, p, got, exp_pkts[p]);
      end
    end
    n_cmp++;
    if (rdy_bad != 0) begin
      n_err++;
      $display("FAIL %s ready_low got %0d high cycles in frame want 0", name, rdy_bad);
    end
    n_cmp++;
    if (bus_a.ready !== 1'b1 || sout_a !== 1'b1) begin
      n_err++;
      $display("FAIL %s end_idle got ready=%b sout=%b want 1 1", name, bus_a.ready, sout_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 2;
    if (bus_a.ready !== 1'b1 || sout_a !== 1'b1) begin
      n_err++;
      $display("FAIL reset_a got ready=%b sout=%b want 1 1", bus_a.ready, sout_a);
    end
    if (bus_b.ready !== 1'b1 || sout_b !== 1'b1) begin
      n_err++;
      $display("FAIL reset_b got ready=%b sout=%b want 1 1", bus_b.ready, sout_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_frame();
    run_frame_a("zero", 1'b0, 32'h0, 4'b0010, 6'h0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (got_pkts[p] !== 11'b0_0_00000000_1) begin
        n_err++;
        $display("FAIL zero_hand pkt%0d got %b want 00000000001", p, got_pkts[p]);
      end
    end
    n_cmp++;
    if (got_pkts[4] !== 11'b0_1_00010110_1) begin
      n_err++;
      $display("FAIL zero_hand ctl got %b want 01000101101", got_pkts[4]);
    end
  endtask

  task automatic test_err_frames();
    logic [5:0]  codes [3];
    logic [10:0] hand  [3];
    codes[0] = ERR_DATA; hand[0] = 11'b0_1_11001001_1;
    codes[1] = ERR_CRC;  hand[1] = 11'b0_1_10100101_1;
    codes[2] = ERR_OP;   hand[2] = 11'b0_1_10010011_1;
    for (int i = 0; i < 3; i++) begin
      run_frame_a("err", 1'b1, 32'h1234_5678, 4'hA, codes[i], 1'b0, 1'b0);
      n_cmp++;
      if (got_pkts[0] !== hand[i]) begin
        n_err++;
        $display("FAIL err_hand%0d got %b want %b", i, got_pkts[0], hand[i]);
      end
    end
  endtask

  task automatic test_ones();
    run_frame_a("ones", 1'b0, 32'hFFFF_FFFF, 4'($urandom_range(0, 15)), 6'h0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (got_pkts[p] !== 11'b0_0_11111111_1) begin
        n_err++;
        $display("FAIL ones_hand pkt%0d got %b want 00111111111", p, got_pkts[p]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_frame_a("rand", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  6'($urandom_range(0, 63)), 1'b0, 1'b0);
  endtask

  task automatic test_mid_start();
    int bad;
    run_frame_a("mid", 1'b0, 32'hA5C3_0F81, 4'b1001, 6'h0, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus_a.ready !== 1'b1 || sout_a !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL mid_no_extra got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.is_err = 1'b0; bus_a.data_c = 32'h0F0F_F0F0;
    bus_a.flags = 4'h5; bus_a.err_flags = 6'h0;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.ready !== 1'b1 || sout_a !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid got ready=%b sout=%b want 1 1", bus_a.ready, sout_a);
    end
    rst = 1'b0;
    run_frame_a("rst_then_op", 1'b1, 32'h0, 4'h0, ERR_OP, 1'b0, 1'b0);
    n_cmp++;
    if (got_pkts[0] !== 11'b0_1_10010011_1) begin
      n_err++;
      $display("FAIL rst_then_op_hand got %b want 01100100111", got_pkts[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame_a("b2b_1", 1'b0, 32'hDEAD_BEEF, 4'b0110, 6'h0, 1'b0, 1'b0);
    run_frame_a("b2b_2", 1'b1, 32'h0, 4'h0, ERR_CRC, 1'b1, 1'b0);
    run_frame_a("b2b_3", 1'b0, 32'h0123_4567, 4'b1111, 6'h0, 1'b1, 1'b0);
  endtask

  task automatic test_clks4();
    logic [10:0] hand [2];
    logic [5:0]  codes [2];
    logic [43:0] got, want;
    int low;
    hand[0] = 11'b0_1_11001001_1; codes[0] = ERR_DATA;
    hand[1] = 11'b0_1_10100101_1; codes[1] = ERR_CRC;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      bus_b.start = 1'b1; bus_b.is_err = 1'b1; bus_b.err_flags = codes[f];
      bus_b.data_c = 32'h0; bus_b.flags = 4'h0;
      @(negedge clk);
      bus_b.start = 1'b0;
      low = 0;
      for (int k = 0; k < 44; k++) begin
        want[43-k] = hand[f][10 - k/4];
        got[43-k]  = sout_b;
        if (bus_b.ready === 1'b0) low++;
        @(negedge clk);
      end
      n_cmp += 3;
      if (got !== want) begin
        n_err++;
        $display("FAIL clk4_bits%0d got %b want %b", f, got, want);
      end
      if (low != 44) begin
        n_err++;
        $display("FAIL clk4_ready_low%0d got %0d want 44", f, low);
      end
      if (bus_b.ready !== 1'b1 || sout_b !== 1'b1) begin
        n_err++;
        $display("FAIL clk4_idle%0d got ready=%b sout=%b want 1 1", f, bus_b.ready, sout_b);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.is_err = 1'b0; bus_a.data_c = '0;
    bus_a.flags = '0; bus_a.err_flags = '0;
    bus_b.start = 1'b0; bus_b.is_err = 1'b0; bus_b.data_c = '0;
    bus_b.flags = '0; bus_b.err_flags = '0;
    test_reset();
    test_zero_frame();
    test_err_frames();
    test_ones();
    test_mid_start();
    test_reset_mid();
    test_back_to_back();
    test_clks4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
